// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared-ALU arbiter.
// Requester-side ports are packed per index: op slice i = [5i+4:5i], operand slice i = [32i+31:32i].
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*5-1:0]  req_op;
  logic [NUM_REQ*32-1:0] req_rs1;
  logic [NUM_REQ*32-1:0] req_rs2;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// One op in flight: IDLE (grant) -> EXEC (ALU drives result) -> RESP (hold until consumed).
module alu_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [4:0]   alu_control,
  output logic [31:0]  alu_rs1_val,
  output logic [31:0]  alu_rs2_val,
  input  logic [31:0]  alu_rd_write_val,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [4:0]      alu_control_q, alu_control_d;
  logic [31:0]     rs1_q, rs1_d;
  logic [31:0]     rs2_q, rs2_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  logic [4:0]      op_arr  [NUM_REQ];
  logic [31:0]     rs1_arr [NUM_REQ];
  logic [31:0]     rs2_arr [NUM_REQ];
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr[g]  = bus.req_op[5*g +: 5];
    assign rs1_arr[g] = bus.req_rs1[32*g +: 32];
    assign rs2_arr[g] = bus.req_rs2[32*g +: 32];
  end

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    cand        = wrap_inc(rr_ptr_q);
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  assign bus.req_ready = (state_q == StIdle && !rst && grant_found) ?
                         (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    alu_control_d = 5'd0;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_id_d      = rsp_id_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          alu_control_d = op_arr[grant_idx];
          rs1_d         = rs1_arr[grant_idx];
          rs2_d         = rs2_arr[grant_idx];
          rsp_id_d      = grant_idx;
          rr_ptr_d      = grant_idx;
          state_d       = StExec;
        end
      end
      StExec: begin
        // alu_control_q carries the latched op for exactly this cycle.
        rsp_data_d  = alu_rd_write_val;
        rsp_err_d   = (alu_control_q == 5'd0) || (alu_control_q > 5'd8);
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      alu_control_q <= 5'd0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      alu_control_q <= alu_control_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
    end
  end

  assign alu_control   = alu_control_q;
  assign alu_rs1_val   = rs1_q;
  assign alu_rs2_val   = rs2_q;
  assign busy          = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios then random traffic, checked by a
// predictor/scoreboard and a decoupled response monitor.
module tb_alu_arbiter;
  localparam int unsigned N  = 3;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [31:0]   data;
    logic          err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alu_control;
  logic [31:0] alu_rs1_val, alu_rs2_val, alu_rd_write_val;
  logic        busy;

  logic        tb_v  [N];
  logic [4:0]  tb_op [N];
  logic [31:0] tb_a  [N];
  logic [31:0] tb_b  [N];

  int   n_tests = 0;
  int   n_fail  = 0;
  rsp_t exp_q[$];
  int   acc_cnt = 0;
  int   rsp_cnt = 0;
  int   age     = 0;
  logic [N-1:0] acc_mask = '0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign bus.req_valid[g]         = tb_v[g];
    assign bus.req_op[5*g +: 5]     = tb_op[g];
    assign bus.req_rs1[32*g +: 32]  = tb_a[g];
    assign bus.req_rs2[32*g +: 32]  = tb_b[g];
  end

  alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .alu_control      (alu_control),
    .alu_rs1_val      (alu_rs1_val),
    .alu_rs2_val      (alu_rs2_val),
    .alu_rd_write_val (alu_rd_write_val),
    .busy             (busy)
  );

  function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd2:    return a - b;
      5'd3:    return a ^ b;
      5'd4:    return a | b;
      5'd5:    return a & b;
      5'd6:    return a << b[4:0];
      5'd7:    return a >> b[4:0];
      5'd8:    return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  // Stand-in for the shared combinational ALU.
  assign alu_rd_write_val = alu_ref(alu_control, alu_rs1_val, alu_rs2_val);

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Predictor: runs 3 time units after each rising edge, once inputs have settled.
  initial begin : predictor
    int          last_gnt;
    int          gi;
    logic        busy_exp;
    logic        exec_pend;
    logic [4:0]  exec_op;
    logic [31:0] exec_a, exec_b;
    logic [N-1:0] exp_rdy;
    last_gnt  = N - 1;
    exec_pend = 1'b0;
    exec_op   = '0;
    exec_a    = '0;
    exec_b    = '0;
    forever begin
      @(posedge clk);
      #3;
      acc_mask = '0;
      if (rst) begin
        check("ready_during_reset", 32'(bus.req_ready), 32'd0);
        last_gnt  = N - 1;
        exec_pend = 1'b0;
      end else begin
        busy_exp = (acc_cnt != rsp_cnt);
        check("busy", 32'(busy), 32'(busy_exp));
        if (exec_pend) begin
          check("exec_alu_control", 32'(alu_control), 32'(exec_op));
          check("exec_rs1", alu_rs1_val, exec_a);
          check("exec_rs2", alu_rs2_val, exec_b);
          exec_pend = 1'b0;
        end else begin
          check("alu_control_nop", 32'(alu_control), 32'd0);
        end
        if (busy_exp) age++;
        gi      = -1;
        exp_rdy = '0;
        if (!busy_exp) begin
          for (int j = 1; j <= N; j++) begin
            int i;
            i = (last_gnt + j) % N;
            if (gi < 0 && tb_v[i]) gi = i;
          end
        end
        if (gi >= 0) exp_rdy[gi] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        if (gi >= 0) begin
          exp_q.push_back('{id: IW'(gi), data: alu_ref(tb_op[gi], tb_a[gi], tb_b[gi]),
                            err: (tb_op[gi] == 5'd0 || tb_op[gi] > 5'd8)});
          exec_op      = tb_op[gi];
          exec_a       = tb_a[gi];
          exec_b       = tb_b[gi];
          exec_pend    = 1'b1;
          last_gnt     = gi;
          age          = 0;
          acc_mask[gi] = 1'b1;
          acc_cnt++;
        end
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin : monitor
    rsp_t e;
    logic holding;
    holding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        rsp_cnt = acc_cnt;
        holding = 1'b0;
      end else if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected_valid", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = exp_q[0];
          if (!holding) check("rsp_latency", 32'(age), 32'd2);
          check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          if (bus.rsp_ready) begin
            void'(exp_q.pop_front());
            rsp_cnt++;
          end
        end
        holding = !bus.rsp_ready;
      end else begin
        holding = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    tb_v[i]  = 1'b1;
    tb_op[i] = op;
    tb_a[i]  = a;
    tb_b[i]  = b;
  endtask

  task automatic wait_ready(input int i);
    logic [N-1:0] r;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      r = bus.req_ready;
      if (r[i]) return;
    end
    check("grant_timeout", 32'(bus.req_ready), 32'(1) << i);
  endtask

  task automatic wait_any(output int gi);
    logic [N-1:0] r;
    gi = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      r = bus.req_ready;
      for (int i = 0; i < N; i++) if (r[i] && gi < 0) gi = i;
      if (gi >= 0) return;
    end
    check("any_grant_timeout", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wait_rsp();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) return;
    end
    check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask

  // Present one request on requester i, drop it in the cycle after acceptance.
  task automatic issue(input int i, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    tick();
    set_req(i, op, a, b);
    wait_ready(i);
    tick();
    tb_v[i] = 1'b0;
  endtask

  task automatic new_rand_req(input int i);
    logic [4:0]  op;
    logic [31:0] a, b;
    case ($urandom_range(0, 9))
      0:       op = 5'd0;
      1:       op = 5'($urandom_range(9, 31));
      default: op = 5'($urandom_range(1, 8));
    endcase
    a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
    b = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
    set_req(i, op, a, b);
  endtask

  initial begin : stimulus
    int gi;
    rst           = 1'b1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 5'd1, 32'd1, 32'd1);

    // Reset with every requester valid.
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_alu_control", 32'(alu_control), 32'd0);
    check("rst_alu_rs1", alu_rs1_val, 32'd0);
    check("rst_alu_rs2", alu_rs2_val, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) tb_v[i] = 1'b0;

    // Single ADD.
    issue(0, 5'd1, 32'd5, 32'd7);
    wait_rsp();
    check("add_data", bus.rsp_data, 32'd12);
    check("add_id", 32'(bus.rsp_id), 32'd0);
    check("add_err", 32'(bus.rsp_err), 32'd0);

    // Fairness from a fresh reset: 0,1,0,1.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 5'd8, 32'h8000_0000, 32'd4);
    set_req(1, 5'd2, 32'd3, 32'd5);
    for (int k = 0; k < 4; k++) begin
      wait_any(gi);
      check("rr_order", 32'(gi), 32'(k % 2));
      wait_rsp();
      check("rr_data", bus.rsp_data, (k % 2 == 0) ? 32'hF800_0000 : 32'hFFFF_FFFE);
    end
    tick();
    tb_v[0] = 1'b0;
    tb_v[1] = 1'b0;

    // Backpressure: response held for 5 cycles, no grants meanwhile.
    bus.rsp_ready = 1'b0;
    issue(1, 5'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    set_req(0, 5'd1, 32'd1, 32'd2);
    wait_rsp();
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_data", bus.rsp_data, 32'hFF00_FF00);
      check("stall_id", 32'(bus.rsp_id), 32'd1);
      check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("release_still_valid", 32'(bus.rsp_valid), 32'd1);
    @(negedge clk);
    check("release_done", 32'(bus.rsp_valid), 32'd0);
    check("release_next_grant", 32'(bus.req_ready), 32'd1);
    tick();
    tb_v[0] = 1'b0;
    wait_rsp();
    check("post_stall_add", bus.rsp_data, 32'd3);

    // Undefined op, then a legal op clears the error flag.
    issue(2, 5'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_rsp();
    check("illegal_data", bus.rsp_data, 32'd0);
    check("illegal_err", 32'(bus.rsp_err), 32'd1);
    issue(2, 5'd4, 32'h0000_00FF, 32'h0000_FF00);
    wait_rsp();
    check("legal_err_clear", 32'(bus.rsp_err), 32'd0);
    check("legal_or_data", bus.rsp_data, 32'h0000_FFFF);

    // Reset during EXEC drops the op and restores the pointer.
    tick();
    set_req(1, 5'd1, 32'd10, 32'd20);
    wait_ready(1);
    tick();
    rst     = 1'b1;
    tb_v[1] = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("exec_rst_busy", 32'(busy), 32'd0);
    check("exec_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    for (int i = 0; i < N; i++) set_req(i, 5'd5, 32'hFFFF_0000, 32'h0F0F_0F0F);
    @(negedge clk);
    check("exec_rst_ptr", 32'(bus.req_ready), 32'd1);
    tick();
    for (int i = 0; i < N; i++) tb_v[i] = 1'b0;
    wait_rsp();
    check("exec_rst_and", bus.rsp_data, 32'h0F0F_0000);

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i]) begin
          if ($urandom_range(0, 1) == 1) new_rand_req(i);
          else tb_v[i] = 1'b0;
        end else if (tb_v[i]) begin
          if ($urandom_range(0, 9) == 0) tb_v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_rand_req(i);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    tick();
    for (int i = 0; i < N; i++) tb_v[i] = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 30 && acc_cnt != rsp_cnt; c++) @(negedge clk);
    check("drain_outstanding", 32'(acc_cnt - rsp_cnt), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
